// File: rtl/sa_aw_arbiter_if.sv
// -----------------------------------------------------------------------------
// sa_aw_arbiter_if
//
// Groups every bus-level signal of the write-address arbiter of one slave
// port: the per-master AW request buses coming from the dispatchers, the
// registered AW channel going to the slave, the WDATA ordering-FIFO push
// port and the B-completion pulse. Signal names keep the _i/_o suffixes as
// seen from the arbiter, so the arbiter uses the "slave" modport and the
// surrounding logic (dispatchers, slave, FIFO, B tracker) uses "master".
//
// Parameters:
//   MST_AMT           number of masters/dispatchers
//   MST_ID_W          master ID width
//   ADDR_WIDTH        AWADDR width
//   TRANS_DATA_LEN_W  AWLEN width
// -----------------------------------------------------------------------------
interface sa_aw_arbiter_if #(
    parameter int MST_AMT          = 3,
    parameter int MST_ID_W         = $clog2(MST_AMT),
    parameter int ADDR_WIDTH       = 32,
    parameter int TRANS_DATA_LEN_W = 3
);
    // Dispatcher side: master m occupies slice m of the packed buses
    logic [ADDR_WIDTH*MST_AMT-1:0]       dsp_AWADDR_i;
    logic [TRANS_DATA_LEN_W*MST_AMT-1:0] dsp_AWLEN_i;
    logic [MST_AMT-1:0]                  dsp_AWVALID_i;
    logic [MST_AMT-1:0]                  dsp_slv_sel_i;
    logic [MST_AMT-1:0]                  dsp_AWREADY_o;

    // Slave AW channel
    logic [ADDR_WIDTH-1:0]               s_AWADDR_o;
    logic [TRANS_DATA_LEN_W-1:0]         s_AWLEN_o;
    logic [MST_ID_W-1:0]                 s_AWID_o;
    logic                                s_AWVALID_o;
    logic                                s_AWREADY_i;

    // WDATA ordering FIFO push port
    logic [MST_ID_W-1:0]                 WD_mst_id_o;
    logic [TRANS_DATA_LEN_W-1:0]         WD_AxLEN_o;
    logic                                WD_fifo_order_wr_en_o;
    logic                                WD_stall_i;

    // Completed write response on this slave
    logic                                B_done_i;

    // Arbiter view
    modport slave (
        input  dsp_AWADDR_i, dsp_AWLEN_i, dsp_AWVALID_i, dsp_slv_sel_i,
        output dsp_AWREADY_o,
        output s_AWADDR_o, s_AWLEN_o, s_AWID_o, s_AWVALID_o,
        input  s_AWREADY_i,
        output WD_mst_id_o, WD_AxLEN_o, WD_fifo_order_wr_en_o,
        input  WD_stall_i,
        input  B_done_i
    );

    // Environment view (dispatchers, slave, FIFO, B tracker)
    modport master (
        output dsp_AWADDR_i, dsp_AWLEN_i, dsp_AWVALID_i, dsp_slv_sel_i,
        input  dsp_AWREADY_o,
        input  s_AWADDR_o, s_AWLEN_o, s_AWID_o, s_AWVALID_o,
        output s_AWREADY_i,
        input  WD_mst_id_o, WD_AxLEN_o, WD_fifo_order_wr_en_o,
        output WD_stall_i,
        output B_done_i
    );
endinterface

// File: rtl/sa_aw_arbiter.sv
// -----------------------------------------------------------------------------
// sa_aw_arbiter
//
// Write-address arbiter and sequencer for one slave port of the AXI4
// interconnect. Selects one requesting dispatcher per cycle, forwards its
// AW payload through a one-entry registered slice to the slave, and pushes
// {master ID, AWLEN} into the WDATA ordering FIFO in the grant cycle, so
// write data is replayed in grant order. Limits the number of granted AW
// transactions that have not yet seen their B response.
//
// Ports:
//   ACLK_i    clock, rising edge
//   ARESET_i  asynchronous active-high reset
//   bus       sa_aw_arbiter_if.slave: dispatcher requests/ready, slave AW
//             channel, ordering-FIFO push/stall, B completion pulse
//
// Build option:
//   SA_AW_RR_EN  defined   -> round-robin arbitration, pointer = last grant
//                undefined -> fixed priority, lowest master index wins
// -----------------------------------------------------------------------------
module sa_aw_arbiter #(
    parameter int MST_AMT          = 3,
    parameter int OUTSTANDING_AMT  = 8,
    parameter int MST_ID_W         = $clog2(MST_AMT),
    parameter int ADDR_WIDTH       = 32,
    parameter int TRANS_DATA_LEN_W = 3
) (
    input  logic           ACLK_i,
    input  logic           ARESET_i,
    sa_aw_arbiter_if.slave bus
);
    localparam int                    CNT_W   = $clog2(OUTSTANDING_AMT + 1);
    localparam logic [CNT_W-1:0]      CNT_MAX = CNT_W'(OUTSTANDING_AMT);
    localparam logic [MST_ID_W-1:0]   ID_LAST = MST_ID_W'(MST_AMT - 1);

    typedef enum logic {
        SLICE_EMPTY = 1'b0,
        SLICE_FULL  = 1'b1
    } slice_state_t;

    slice_state_t                state_q, state_d;
    logic [ADDR_WIDTH-1:0]       addr_q, addr_d;
    logic [TRANS_DATA_LEN_W-1:0] len_q, len_d;
    logic [MST_ID_W-1:0]         id_q, id_d;
    logic [CNT_W-1:0]            out_cnt_q, out_cnt_d;

    logic [ADDR_WIDTH-1:0]       mst_addr [MST_AMT];
    logic [TRANS_DATA_LEN_W-1:0] mst_len  [MST_AMT];
    logic [MST_AMT-1:0]          req;
    logic [MST_ID_W-1:0]         rr_ptr;
    logic [MST_ID_W-1:0]         winner;
    logic                        slot_free;
    logic                        grant_en;
    logic                        b_dec;

    // Unpack the per-master buses and build the request vector
    generate
        for (genvar gi = 0; gi < MST_AMT; gi++) begin : g_mst
            assign mst_addr[gi] = bus.dsp_AWADDR_i[gi*ADDR_WIDTH +: ADDR_WIDTH];
            assign mst_len[gi]  = bus.dsp_AWLEN_i[gi*TRANS_DATA_LEN_W +: TRANS_DATA_LEN_W];
            assign req[gi]      = bus.dsp_AWVALID_i[gi] & bus.dsp_slv_sel_i[gi];
        end
    endgenerate

    // The slice can accept a new beat when empty, or when its current
    // content leaves this very cycle.
    assign slot_free = (state_q == SLICE_EMPTY) | bus.s_AWREADY_i;

    // Reset gates the grant combinationally so no push escapes while the
    // slice is being cleared asynchronously.
    assign grant_en = ~ARESET_i & slot_free & ~bus.WD_stall_i
                    & (out_cnt_q != CNT_MAX) & (|req);

`ifdef SA_AW_RR_EN
    logic [MST_ID_W-1:0] last_q, last_d;

    assign rr_ptr = last_q;

    always_comb begin
        last_d = last_q;
        if (grant_en) begin
            last_d = winner;
        end
    end

    always_ff @(posedge ACLK_i or posedge ARESET_i) begin
        if (ARESET_i) begin
            last_q <= ID_LAST;
        end else begin
            last_q <= last_d;
        end
    end
`else
    // Pinning the search pointer at the top index makes the wrap-around
    // search start at master 0, i.e. plain lowest-index priority.
    assign rr_ptr = ID_LAST;
`endif

    // Search from rr_ptr+1 upwards with wrap; first requester wins
    always_comb begin : p_winner
        logic [MST_ID_W-1:0] cand;
        logic                found;
        winner = '0;
        found  = 1'b0;
        cand   = rr_ptr;
        for (int k = 0; k < MST_AMT; k++) begin
            cand = (cand == ID_LAST) ? '0 : cand + MST_ID_W'(1);
            if (!found && req[cand]) begin
                winner = cand;
                found  = 1'b1;
            end
        end
    end

    // Output slice next state and payload
    always_comb begin
        state_d = state_q;
        addr_d  = addr_q;
        len_d   = len_q;
        id_d    = id_q;
        case (state_q)
            SLICE_EMPTY: begin
                if (grant_en) begin
                    state_d = SLICE_FULL;
                end
            end
            SLICE_FULL: begin
                if (!grant_en && bus.s_AWREADY_i) begin
                    state_d = SLICE_EMPTY;
                end
            end
        endcase
        if (grant_en) begin
            addr_d = mst_addr[winner];
            len_d  = mst_len[winner];
            id_d   = winner;
        end
    end

    // Outstanding counter; a B pulse with nothing outstanding is dropped
    assign b_dec = bus.B_done_i & (out_cnt_q != '0);

    always_comb begin
        out_cnt_d = out_cnt_q;
        case ({grant_en, b_dec})
            2'b10:   out_cnt_d = out_cnt_q + CNT_W'(1);
            2'b01:   out_cnt_d = out_cnt_q - CNT_W'(1);
            default: out_cnt_d = out_cnt_q;
        endcase
    end

    always_ff @(posedge ACLK_i or posedge ARESET_i) begin
        if (ARESET_i) begin
            state_q   <= SLICE_EMPTY;
            addr_q    <= '0;
            len_q     <= '0;
            id_q      <= '0;
            out_cnt_q <= '0;
        end else begin
            state_q   <= state_d;
            addr_q    <= addr_d;
            len_q     <= len_d;
            id_q      <= id_d;
            out_cnt_q <= out_cnt_d;
        end
    end

    // Grant / FIFO push are same-cycle combinational outputs
    assign bus.dsp_AWREADY_o         = grant_en ? (MST_AMT'(1) << winner) : '0;
    assign bus.WD_fifo_order_wr_en_o = grant_en;
    assign bus.WD_mst_id_o           = grant_en ? winner : '0;
    assign bus.WD_AxLEN_o            = grant_en ? mst_len[winner] : '0;

    assign bus.s_AWVALID_o = (state_q == SLICE_FULL);
    assign bus.s_AWADDR_o  = addr_q;
    assign bus.s_AWLEN_o   = len_q;
    assign bus.s_AWID_o    = id_q;

endmodule
